fsm_nxm_matrix_scan: RTL and testbench
======================================

Name: fsm_nxm_matrix_scan

Overview:
- Parametrised successor of the fixed 2x2 single-value matrix sequencer.
- Programs the bias DAC once per frame, then scans an ROWS x COLS pixel array.
- Takes NSAMP ADC conversions per pixel, with a programmable settle delay after every row change.
- Holds the row/column/sample counters internally, optionally free-runs frame after frame, and accepts an abort. Sits between the top-level control register and the DAC/ADC SPI drivers and capture memory.

Parameters:
- ROWS, 4, number of matrix rows (>=1)
- COLS, 4, number of matrix columns (>=1)
- NSAMP, 1, ADC conversions per pixel (>=1)
- SETTLE_W, 8, width of settle-delay count

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start a scan (sampled in IDLE only)
- cont_i  in  1  continuous mode; sampled at frame end
- abort_i  in  1  stop scan, return to IDLE
- settle_i  in  SETTLE_W  extra settle cycles after each row select
- eodac_i  in  1  DAC driver end-of-conversion pulse
- eoadc_i  in  1  ADC driver end-of-conversion pulse
- stdac_o  out  1  one-cycle DAC start pulse
- stadc_o  out  1  one-cycle ADC start pulse
- sample_o  out  1  one-cycle capture strobe; row_o/col_o/sidx_o valid with it
- row_o  out  RW=max(1,clog2(ROWS))  current row index
- col_o  out  CW=max(1,clog2(COLS))  current column index
- sidx_o  out  SW=max(1,clog2(NSAMP))  current sample index
- frame_done_o  out  1  one-cycle pulse after last sample of last pixel
- busy_o  out  1  high in every non-IDLE state
- eos_o  out  1  end-of-scan, equals !busy_o

Behaviour:
- Reset (rst_ni low, async): state IDLE; row/col/sidx/settle counter = 0; stdac_o, stadc_o, sample_o, frame_done_o, busy_o = 0; eos_o = 1.
- Moore outputs decoded from state. Counters are registered and update on the clock edge leaving STORE/SETTLE.
- IDLE: eos_o=1. start_i=1 -> DAC_START.
- DAC_START: stdac_o=1 for exactly 1 cycle -> DAC_WAIT.
- DAC_WAIT: hold until eoadc-independent eodac_i=1 -> SETTLE; settle counter loads settle_i.
- SETTLE: lasts settle_i+1 cycles (settle_i=0 gives 1 cycle) -> ADC_START.
- ADC_START: stadc_o=1 for 1 cycle -> ADC_WAIT.
- ADC_WAIT: hold until eoadc_i=1 -> STORE.
- STORE: sample_o=1 for 1 cycle. Next state, by priority:
  - sidx<NSAMP-1: sidx++ -> ADC_START
  - else col<COLS-1: sidx=0, col++ -> ADC_START
  - else row<ROWS-1: sidx=0, col=0, row++ -> SETTLE (reload settle_i)
  - else (last pixel): frame_done_o=1 this cycle; counters -> 0. cont_i=1 -> SETTLE with DAC not reprogrammed; cont_i=0 -> IDLE.
- abort_i=1 in any non-IDLE state: next state IDLE, counters cleared, no frame_done_o. Abort has priority over every other transition, including frame end.
- In IDLE, simultaneous start_i and abort_i: abort wins, stay IDLE.
- eodac_i/eoadc_i outside their WAIT state are ignored. A pulse coincident with the start-pulse cycle is not counted.
- start_i while busy is ignored. cont_i is only sampled in the final STORE.
- No counter ever exceeds ROWS-1 / COLS-1 / NSAMP-1. ROWS, COLS or NSAMP = 1 degenerates the corresponding field to constant 0.
- Undefined state encoding -> IDLE.
- Pixel time with instantaneous ADC (eoadc_i in first ADC_WAIT cycle) = 3 cycles per sample.

Decomposition:
- Package nxm_scan_pkg: state enum (IDLE, DAC_START, DAC_WAIT, SETTLE, ADC_START, ADC_WAIT, STORE), a clog2-with-min-1 width function, default parameter constants.
- Sub-module nxm_scan_counter: nested sample/column/row counter with clear, step, last_sample/last_col/last_row flags, parametrised by ROWS/COLS/NSAMP.
- Settle down-counter stays inline.

Test Plan:
- ROWS=2,COLS=3,NSAMP=1, settle_i=0, eodac/eoadc returned 2 cycles after start -> one stdac_o, exactly 6 sample_o with (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), one frame_done_o, back to IDLE with eos_o=1.
- NSAMP=3, 1x1 -> sample_o with sidx_o = 0,1,2, three stadc_o pulses, frame_done_o coincident with the third sample_o.
- settle_i=5, ROWS=2 -> exactly 6 SETTLE cycles before the first stadc_o of each row; settle_i=0 -> exactly 1.
- cont_i=1 over 2 frames -> stdac_o once only, frame_done_o twice, row/col wrap to 0. Then cont_i=0 -> IDLE after frame 3.
- abort_i mid-ADC_WAIT at (1,2), and abort_i with start_i in IDLE -> IDLE next cycle, counters 0, no frame_done_o, late eoadc_i ignored.
- rst_ni low mid-scan (async, between edges) -> outputs at reset values immediately. Spurious eoadc_i in SETTLE -> no sample_o.

Source files
------------

// File: rtl/nxm_scan_pkg.sv
// Shared types and helpers for the NxM matrix scan sequencer.
package nxm_scan_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DAC_START = 3'd1,
        DAC_WAIT  = 3'd2,
        SETTLE    = 3'd3,
        ADC_START = 3'd4,
        ADC_WAIT  = 3'd5,
        STORE     = 3'd6
    } state_e;

    localparam int unsigned DEF_ROWS     = 4;
    localparam int unsigned DEF_COLS     = 4;
    localparam int unsigned DEF_NSAMP    = 1;
    localparam int unsigned DEF_SETTLE_W = 8;

    // Index width for n entries; a single-entry field still needs one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nxm_scan_counter.sv
// Nested sample/column/row counter; sample is the fastest-moving field.
module nxm_scan_counter
    import nxm_scan_pkg::*;
#(
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned COLS  = DEF_COLS,
    parameter int unsigned NSAMP = DEF_NSAMP,
    localparam int unsigned RW = clog2_min1(ROWS),
    localparam int unsigned CW = clog2_min1(COLS),
    localparam int unsigned SW = clog2_min1(NSAMP)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          step_i,
    output logic [RW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic [SW-1:0] sidx_o,
    output logic          last_sample_o,
    output logic          last_col_o,
    output logic          last_row_o
);

    localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
    localparam logic [SW-1:0] SAMP_MAX = SW'(NSAMP - 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [SW-1:0] sidx_q, sidx_d;

    assign last_sample_o = (sidx_q == SAMP_MAX);
    assign last_col_o    = (col_q == COL_MAX);
    assign last_row_o    = (row_q == ROW_MAX);

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        sidx_d = sidx_q;
        if (clr_i) begin
            row_d  = '0;
            col_d  = '0;
            sidx_d = '0;
        end else if (step_i) begin
            if (!last_sample_o) begin
                sidx_d = sidx_q + SW'(1);
            end else begin
                sidx_d = '0;
                if (!last_col_o) begin
                    col_d = col_q + CW'(1);
                end else begin
                    col_d = '0;
                    row_d = last_row_o ? '0 : row_q + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q  <= '0;
            col_q  <= '0;
            sidx_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            sidx_q <= sidx_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign sidx_o = sidx_q;

endmodule

// File: rtl/fsm_nxm_matrix_scan.sv
// Frame sequencer: program bias DAC once, then settle/convert/store each pixel
// of a ROWS x COLS array with NSAMP conversions per pixel.
module fsm_nxm_matrix_scan
    import nxm_scan_pkg::*;
#(
    parameter int unsigned ROWS     = DEF_ROWS,
    parameter int unsigned COLS     = DEF_COLS,
    parameter int unsigned NSAMP    = DEF_NSAMP,
    parameter int unsigned SETTLE_W = DEF_SETTLE_W,
    localparam int unsigned RW = clog2_min1(ROWS),
    localparam int unsigned CW = clog2_min1(COLS),
    localparam int unsigned SW = clog2_min1(NSAMP)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                cont_i,
    input  logic                abort_i,
    input  logic [SETTLE_W-1:0] settle_i,
    input  logic                eodac_i,
    input  logic                eoadc_i,
    output logic                stdac_o,
    output logic                stadc_o,
    output logic                sample_o,
    output logic [RW-1:0]       row_o,
    output logic [CW-1:0]       col_o,
    output logic [SW-1:0]       sidx_o,
    output logic                frame_done_o,
    output logic                busy_o,
    output logic                eos_o
);

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                cnt_clr, cnt_step;
    logic                last_s, last_c, last_r, last_pixel;

    assign last_pixel = last_s & last_c & last_r;
    // Entering IDLE by any route (abort, frame end, bad encoding) zeroes the indices.
    assign cnt_clr    = (state_d == IDLE);
    assign cnt_step   = (state_q == STORE);

    nxm_scan_counter #(
        .ROWS (ROWS),
        .COLS (COLS),
        .NSAMP(NSAMP)
    ) u_counter (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (cnt_clr),
        .step_i       (cnt_step),
        .row_o        (row_o),
        .col_o        (col_o),
        .sidx_o       (sidx_o),
        .last_sample_o(last_s),
        .last_col_o   (last_c),
        .last_row_o   (last_r)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (start_i) state_d = DAC_START;
            DAC_START: state_d = DAC_WAIT;
            DAC_WAIT:  if (eodac_i) state_d = SETTLE;
            SETTLE:    if (settle_q == '0) state_d = ADC_START;
            ADC_START: state_d = ADC_WAIT;
            ADC_WAIT:  if (eoadc_i) state_d = STORE;
            STORE: begin
                if (!last_s || !last_c) state_d = ADC_START;
                else if (!last_r)       state_d = SETTLE;
                else if (cont_i)        state_d = SETTLE;
                else                    state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
        if (abort_i) state_d = IDLE;

        settle_d = settle_q;
        if (state_q == SETTLE && settle_q != '0) settle_d = settle_q - SETTLE_W'(1);
        if (state_d == SETTLE && state_q != SETTLE) settle_d = settle_i;
        if (state_d == IDLE) settle_d = '0;
    end

    always_comb begin
        stdac_o      = (state_q == DAC_START);
        stadc_o      = (state_q == ADC_START);
        sample_o     = (state_q == STORE);
        frame_done_o = (state_q == STORE) && last_pixel && !abort_i;
        busy_o       = (state_q != IDLE);
        eos_o        = (state_q == IDLE);
    end

endmodule

// File: tb/tb_fsm_nxm_matrix_scan.sv
// Directed bench: 2x3x1 instance for scan/settle/cont/abort/reset, 1x1x3 for multi-sample.
module tb_fsm_nxm_matrix_scan;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // 2x3, one sample per pixel
    logic       a_start = 0, a_cont = 0, a_abort = 0, a_eodac = 0, a_eoadc = 0;
    logic [7:0] a_settle = 8'd0;
    logic       a_stdac, a_stadc, a_sample, a_fd, a_busy, a_eos;
    logic [0:0] a_row;
    logic [1:0] a_col;
    logic [0:0] a_sidx;

    // 1x1, three samples per pixel
    logic       b_start = 0, b_cont = 0, b_abort = 0, b_eodac = 0, b_eoadc = 0;
    logic [7:0] b_settle = 8'd0;
    logic       b_stdac, b_stadc, b_sample, b_fd, b_busy, b_eos;
    logic [0:0] b_row;
    logic [0:0] b_col;
    logic [1:0] b_sidx;

    fsm_nxm_matrix_scan #(.ROWS(2), .COLS(3), .NSAMP(1), .SETTLE_W(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .cont_i(a_cont), .abort_i(a_abort),
        .settle_i(a_settle), .eodac_i(a_eodac), .eoadc_i(a_eoadc), .stdac_o(a_stdac),
        .stadc_o(a_stadc), .sample_o(a_sample), .row_o(a_row), .col_o(a_col), .sidx_o(a_sidx),
        .frame_done_o(a_fd), .busy_o(a_busy), .eos_o(a_eos)
    );

    fsm_nxm_matrix_scan #(.ROWS(1), .COLS(1), .NSAMP(3), .SETTLE_W(8)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .cont_i(b_cont), .abort_i(b_abort),
        .settle_i(b_settle), .eodac_i(b_eodac), .eoadc_i(b_eoadc), .stdac_o(b_stdac),
        .stadc_o(b_stadc), .sample_o(b_sample), .row_o(b_row), .col_o(b_col), .sidx_o(b_sidx),
        .frame_done_o(b_fd), .busy_o(b_busy), .eos_o(b_eos)
    );

    int n_stdac_a = 0, n_sample_a = 0, n_fd_a = 0, n_stadc_b = 0;
    always @(negedge clk) begin
        if (a_stdac)  n_stdac_a++;
        if (a_sample) n_sample_a++;
        if (a_fd)     n_fd_a++;
        if (b_stadc)  n_stadc_b++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in DAC_START; eodac returns two cycles after the start pulse.
    task automatic dac_a(input bit early);
        chk("a_stdac", int'(a_stdac), 1);
        a_eodac = early;
        tick();
        a_eodac = 0;
        tick();
        a_eodac = 1;
        tick();
        a_eodac = 0;
    endtask

    // Counts SETTLE cycles up to the first ADC start pulse.
    task automatic settle_a(input int exp_n, input bit spur);
        int n = 0;
        while (!a_stadc && n < 64) begin
            n++;
            a_eoadc = spur && (n == 1);
            tick();
        end
        a_eoadc = 0;
        chk("a_settle_cycles", n, exp_n);
    endtask

    // Starts in ADC_START; eoadc returns two cycles after the start pulse.
    task automatic pixel_a(input int r, input int c, input int last);
        chk("a_stadc", int'(a_stadc), 1);
        tick();
        tick();
        a_eoadc = 1;
        tick();
        a_eoadc = 0;
        chk("a_sample", int'(a_sample), 1);
        chk("a_row", int'(a_row), r);
        chk("a_col", int'(a_col), c);
        chk("a_sidx", int'(a_sidx), 0);
        chk("a_frame_done", int'(a_fd), last);
        tick();
    endtask

    task automatic body_a(input int exp_settle, input bit spur);
        for (int r = 0; r < 2; r++) begin
            settle_a(exp_settle, spur && (r == 0));
            for (int c = 0; c < 3; c++) pixel_a(r, c, int'(r == 1 && c == 2));
        end
    endtask

    int s0, f0, d0, b0;

    initial begin
        // Reset values
        #1 rst_n = 0;
        #2;
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_eos", int'(a_eos), 1);
        chk("rst_stdac", int'(a_stdac), 0);
        chk("rst_sample", int'(a_sample), 0);
        chk("rst_fd", int'(a_fd), 0);
        chk("rst_rowcol", int'({a_row, a_col}), 0);
        chk("rst_b_eos", int'(b_eos), 1);
        #10 rst_n = 1;
        tick();

        // Frame A: settle 0, early eodac in DAC_START ignored
        d0 = n_stdac_a; s0 = n_sample_a; f0 = n_fd_a;
        a_start = 1;
        tick();
        a_start = 0;
        chk("a_busy_start", int'(a_busy), 1);
        chk("a_eos_start", int'(a_eos), 0);
        dac_a(1'b1);
        body_a(1, 1'b0);
        chk("a_idle_busy", int'(a_busy), 0);
        chk("a_idle_eos", int'(a_eos), 1);
        chk("a_idle_rowcol", int'({a_row, a_col}), 0);
        chk("a_stdac_count", n_stdac_a - d0, 1);
        chk("a_sample_count", n_sample_a - s0, 6);
        chk("a_fd_count", n_fd_a - f0, 1);

        // Continuous mode over three frames, settle 5, spurious eoadc in SETTLE
        d0 = n_stdac_a; s0 = n_sample_a; f0 = n_fd_a;
        a_settle = 8'd5;
        a_cont = 1;
        a_start = 1;
        tick();
        a_start = 0;
        dac_a(1'b0);
        body_a(6, 1'b1);
        chk("cont_busy_f1", int'(a_busy), 1);
        chk("cont_wrap_f1", int'({a_row, a_col}), 0);
        body_a(6, 1'b0);
        chk("cont_fd_2frames", n_fd_a - f0, 2);
        chk("cont_stdac_2frames", n_stdac_a - d0, 1);
        a_cont = 0;
        body_a(6, 1'b0);
        chk("cont_idle_busy", int'(a_busy), 0);
        chk("cont_fd_3frames", n_fd_a - f0, 3);
        chk("cont_samples", n_sample_a - s0, 18);
        chk("cont_stdac_3frames", n_stdac_a - d0, 1);

        // Abort during ADC_WAIT of pixel (1,2); late eoadc ignored
        f0 = n_fd_a; s0 = n_sample_a;
        a_settle = 8'd0;
        a_start = 1;
        tick();
        a_start = 0;
        dac_a(1'b0);
        settle_a(1, 1'b0);
        for (int c = 0; c < 3; c++) pixel_a(0, c, 0);
        settle_a(1, 1'b0);
        pixel_a(1, 0, 0);
        pixel_a(1, 1, 0);
        chk("abort_pre_stadc", int'(a_stadc), 1);
        tick();
        a_abort = 1;
        tick();
        a_abort = 0;
        chk("abort_busy", int'(a_busy), 0);
        chk("abort_rowcol", int'({a_row, a_col}), 0);
        chk("abort_fd", int'(a_fd), 0);
        a_eoadc = 1;
        tick();
        a_eoadc = 0;
        chk("abort_late_sample", int'(a_sample), 0);
        chk("abort_late_busy", int'(a_busy), 0);
        chk("abort_fd_count", n_fd_a - f0, 0);
        chk("abort_sample_count", n_sample_a - s0, 5);

        // Start and abort together in IDLE
        a_start = 1;
        a_abort = 1;
        tick();
        a_start = 0;
        a_abort = 0;
        chk("startabort_busy", int'(a_busy), 0);
        chk("startabort_stdac", int'(a_stdac), 0);

        // Asynchronous reset between edges mid-scan
        a_start = 1;
        tick();
        a_start = 0;
        dac_a(1'b0);
        settle_a(1, 1'b0);
        pixel_a(0, 0, 0);
        chk("arst_pre_col", int'(a_col), 1);
        #2 rst_n = 0;
        #1;
        chk("arst_busy", int'(a_busy), 0);
        chk("arst_eos", int'(a_eos), 1);
        chk("arst_stadc", int'(a_stadc), 0);
        chk("arst_col", int'(a_col), 0);
        #3 rst_n = 1;
        tick();
        chk("arst_stays_idle", int'(a_busy), 0);

        // 1x1 pixel, three samples
        b0 = n_stadc_b;
        b_start = 1;
        tick();
        b_start = 0;
        chk("b_stdac", int'(b_stdac), 1);
        tick();
        tick();
        b_eodac = 1;
        tick();
        b_eodac = 0;
        tick();
        for (int s = 0; s < 3; s++) begin
            chk("b_stadc", int'(b_stadc), 1);
            tick();
            tick();
            b_eoadc = 1;
            tick();
            b_eoadc = 0;
            chk("b_sample", int'(b_sample), 1);
            chk("b_sidx", int'(b_sidx), s);
            chk("b_rowcol", int'({b_row, b_col}), 0);
            chk("b_frame_done", int'(b_fd), int'(s == 2));
            tick();
        end
        chk("b_idle_busy", int'(b_busy), 0);
        chk("b_idle_eos", int'(b_eos), 1);
        chk("b_idle_sidx", int'(b_sidx), 0);
        chk("b_stadc_count", n_stadc_b - b0, 3);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
